// File: rtl/uart_tx_framer.sv
// Transmit framer: snapshots signalNumber/adder/amplitude on send and streams an
// 11-byte frame (SOM, sig, adder MSB..LSB, amplitude MSB..LSB, EOM) to the UART core.
// Latency: SOM valid the cycle after an accepted send; backpressure holds data/valid stable.
module uart_tx_framer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send,
  input  logic [7:0]  signalNumber,
  input  logic [31:0] adder,
  input  logic [31:0] amplitude,
  output logic        busy,
  output logic        done,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  input  logic        to_uart_ready
);

  localparam logic [7:0] SOM      = 8'h73;
  localparam logic [7:0] EOM      = 8'h65;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Frame snapshot, taken once per accepted send.
  logic [7:0]  r_sig;
  logic [31:0] r_adder;
  logic [31:0] r_amp;

  // Registered outputs; nothing on the sink side is combinational from ready.
  logic [3:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_idx_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_capture;
  logic        w_accept;
  logic [3:0]  w_idx_inc;
  logic [7:0]  w_next_byte;

  assign w_accept  = r_valid & to_uart_ready;
  assign w_idx_inc = r_idx + 4'd1;

  // Byte that follows the one currently on the bus, drawn from the snapshot.
  always_comb begin
    w_next_byte = SOM;
    case (w_idx_inc)
      4'd1:    w_next_byte = r_sig;
      4'd2:    w_next_byte = r_adder[31:24];
      4'd3:    w_next_byte = r_adder[23:16];
      4'd4:    w_next_byte = r_adder[15:8];
      4'd5:    w_next_byte = r_adder[7:0];
      4'd6:    w_next_byte = r_amp[31:24];
      4'd7:    w_next_byte = r_amp[23:16];
      4'd8:    w_next_byte = r_amp[15:8];
      4'd9:    w_next_byte = r_amp[7:0];
      4'd10:   w_next_byte = EOM;
      default: w_next_byte = SOM;
    endcase
  end

  // Next-state and next-output logic for the IDLE -> SEND -> DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (send) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 4'd0;
          w_data_nxt  = SOM;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SEND: begin
        // Without acceptance everything holds, so a stalled sink sees stable data.
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_idx_nxt   = 4'd0;
            w_data_nxt  = 8'h00;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = w_next_byte;
          end
        end
      end
      ST_DONE: begin
        // One-cycle completion pulse; a send seen here is dropped.
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
        w_data_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, index and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Snapshot registers, loaded only when a send is accepted from IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig   <= 8'h00;
      r_adder <= 32'h0;
      r_amp   <= 32'h0;
    end else if (w_capture) begin
      r_sig   <= signalNumber;
      r_adder <= adder;
      r_amp   <= amplitude;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign to_uart_data  = r_data;
  assign to_uart_valid = r_valid;

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

  logic        clk;
  logic        reset_n;
  logic        send;
  logic [7:0]  signalNumber;
  logic [31:0] adder;
  logic [31:0] amplitude;
  logic        busy;
  logic        done;
  logic [7:0]  to_uart_data;
  logic        to_uart_valid;
  logic        to_uart_ready;

  int vectors;
  int miscompares;
  logic [7:0] rx_q[$];

  uart_tx_framer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .send         (send),
    .signalNumber (signalNumber),
    .adder        (adder),
    .amplitude    (amplitude),
    .busy         (busy),
    .done         (done),
    .to_uart_data (to_uart_data),
    .to_uart_valid(to_uart_valid),
    .to_uart_ready(to_uart_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame: the three fields concatenated between SOM and EOM, MSB first.
  function automatic logic [7:0] frame_byte(input logic [7:0] sig, input logic [31:0] add,
                                            input logic [31:0] amp, input int k);
    logic [87:0] f;
    f = {8'h73, sig, add, amp, 8'h65};
    return f[87 - 8*k -: 8];
  endfunction

  // ready pattern: mode 0 always 1, mode 1 repeating 1,0,0, mode 2 random ~30% stalls.
  // disturb: perturb inputs and pulse send during the frame and during DONE.
  task automatic run_frame(input logic [7:0] sig, input logic [31:0] add,
                           input logic [31:0] amp, input int mode, input bit disturb);
    int k, stalls, edges;
    logic [7:0] pre_d;
    bit acc;
    rx_q.delete();
    signalNumber = sig; adder = add; amplitude = amp; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", to_uart_valid, 1);
    chk("start_done", done, 0);
    chk("start_som", to_uart_data, 8'h73);
    k = 0; stalls = 0; edges = 0;
    while (k < 11 && edges < 300) begin
      case (mode)
        0: to_uart_ready = 1'b1;
        1: to_uart_ready = (edges % 3 == 0);
        default: to_uart_ready = ($urandom_range(99) >= 30);
      endcase
      if (disturb && $urandom_range(2) == 0) begin
        adder = 32'hFFFFFFFF; amplitude = $urandom; signalNumber = 8'($urandom); send = 1'b1;
      end else begin
        send = 1'b0;
      end
      pre_d = to_uart_data;
      acc = to_uart_valid && to_uart_ready;
      @(posedge clk); #1;
      edges++;
      if (acc) begin
        chk($sformatf("byte%0d", k), pre_d, frame_byte(sig, add, amp, k));
        rx_q.push_back(pre_d);
        k++;
      end else begin
        stalls++;
        chk("stall_valid", to_uart_valid, 1);
        chk("stall_data", to_uart_data, pre_d);
      end
      if (k < 11) begin
        chk("send_busy", busy, 1);
        chk("send_done", done, 0);
        chk("send_valid", to_uart_valid, 1);
      end
    end
    send = 1'b0;
    chk("frame_len", edges, 11 + stalls);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", to_uart_valid, 0);
    if (disturb) send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", to_uart_valid, 0);
  endtask

  // Receive-side parser: validates delimiters and rebuilds the fields arithmetically.
  task automatic loopback(input int exp_sig, input longint exp_add, input longint exp_amp);
    longint a, m;
    chk("lb_len", rx_q.size(), 11);
    if (rx_q.size() == 11) begin
      chk("lb_som", rx_q[0], 8'h73);
      chk("lb_eom", rx_q[10], 8'h65);
      a = 0; m = 0;
      for (int i = 2; i < 6; i++) a = a * 256 + rx_q[i];
      for (int i = 6; i < 10; i++) m = m * 256 + rx_q[i];
      chk("lb_sig", rx_q[1], exp_sig);
      chk("lb_adder", a, exp_add);
      chk("lb_amp", m, exp_amp);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, {busy, done, to_uart_valid}, 3'b000);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; send = 1'b0; to_uart_ready = 1'b1;
    signalNumber = 8'h00; adder = 32'h0; amplitude = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", to_uart_valid, 0);
    chk("rst_data", to_uart_data, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    idle_watch("post_rst_idle", 3);

    // Basic frame plus loopback reconstruction.
    run_frame(8'h02, 32'h0014DF75, 32'h000F4240, 0, 1'b0);
    loopback(2, 1367925, 1000000);

    // Back-to-back: send on the first IDLE cycle after done.
    run_frame(8'h05, 32'h0014DF75, 32'h000F4240, 0, 1'b0);
    chk("b2b_sig", rx_q[1], 8'h05);

    // Backpressure with ready 1,0,0 repeating.
    run_frame(8'h02, 32'h0014DF75, 32'h000F4240, 1, 1'b0);
    loopback(2, 1367925, 1000000);

    // Snapshot holds and mid-frame / DONE-cycle sends are ignored.
    run_frame(8'h02, 32'h0014DF75, 32'h000F4240, 0, 1'b1);
    loopback(2, 1367925, 1000000);
    idle_watch("no_second_frame", 6);

    // Random frames with random backpressure and disturbances.
    for (int n = 0; n < 20; n++) begin
      run_frame(8'($urandom), $urandom, $urandom, 2, ($urandom_range(1) == 1));
      if ($urandom_range(1) == 1) idle_watch("rand_gap", $urandom_range(1, 3));
    end

    // Reset after the 4th accepted byte.
    signalNumber = 8'h02; adder = 32'h0014DF75; amplitude = 32'h000F4240;
    to_uart_ready = 1'b1; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_data", to_uart_data, frame_byte(8'h02, 32'h0014DF75, 32'h000F4240, 4));
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", to_uart_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", to_uart_data, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    idle_watch("no_resume", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Transmit-side message framer for the waveform-generator UART link. On a one-cycle `send` request it snapshots a signal number, a 32-bit phase adder and a 32-bit amplitude, then streams one fixed 11-byte frame to the UART core's byte-wide valid/ready sink. The frame format is the same one the receive-side parser accepts, so a looped-back frame reproduces the three values exactly. The block sits between the generator control logic and the UART core's transmit interface.

## Interface
- `SOM`, 8'h73 ('s'), start-of-message byte.
- `EOM`, 8'h65 ('e'), end-of-message byte.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send`  in  1  frame request; sampled only in IDLE.
- `signalNumber`  in  8  value for frame byte 1; captured on an accepted `send`.
- `adder`  in  32  phase increment; captured on an accepted `send`.
- `amplitude`  in  32  amplitude; captured on an accepted `send`.
- `busy`  out  1  high from the cycle after an accepted `send` until the frame completes.
- `done`  out  1  one-cycle pulse after the EOM byte is accepted.
- `to_uart_data`  out  8  current byte.
- `to_uart_valid`  out  1  `to_uart_data` is valid.
- `to_uart_ready`  in  1  the UART core accepts a byte when both valid and ready are high at a rising edge.

## Operation
- Frame byte order, index 0..10: SOM, signalNumber, adder[31:24], adder[23:16], adder[15:8], adder[7:0], amplitude[31:24], amplitude[23:16], amplitude[15:8], amplitude[7:0], EOM.
- Multi-byte fields go MSB first.
- Reset values: `busy`=0, `done`=0, `to_uart_valid`=0, `to_uart_data`=8'h00, byte index=0, state=IDLE, snapshot registers=0.
- **IDLE**
  - `send`=1 captures all three inputs into the snapshot registers, sets index=0 and moves to SEND.
  - `send`=0 stays in IDLE.
- **SEND**
  - `to_uart_valid`=1 and `to_uart_data`=byte[index], both driven from registers.
  - When valid&&ready at an edge and index<10: index increments; the next byte appears on the following cycle and valid stays high (back-to-back bytes).
  - When valid&&ready at an edge and index==10: go to DONE and drop valid.
  - When ready=0: data and valid hold stable, with no change allowed until acceptance.
- **DONE**: `done`=1 for exactly one cycle and `busy`=0, then return to IDLE.
- `send` arriving while in SEND or DONE is ignored. It is neither queued nor counted.
- The snapshot is taken once per frame, so input changes during a frame do not affect the bytes sent.
- `reset_n` low at any time, including mid-frame, immediately clears all outputs to their reset values. The partial frame is abandoned and is not resumed after reset.
- The valid/ready rule matches the UART core: valid never depends combinationally on ready, and valid is never retracted before acceptance except by reset.

## Timing
- Latency: `send` high at edge t → `busy`=1 and valid=1 with SOM on the cycle after t.
- With ready held at 1:
  - bytes are accepted at edges t+1 … t+11;
  - valid=0 and `done`=1 during the cycle after edge t+11;
  - IDLE during the cycle after that;
  - the earliest next accepted `send` is at edge t+13.
- Minimum frame duration is therefore 12 cycles from request to `done`.
- Each ready=0 cycle seen while valid=1 stretches the frame by exactly one cycle.
- `busy` is high for exactly the SEND cycles.
- `done` and `busy` are never high in the same cycle.
- There is no internal timeout: an indefinitely stalled sink holds the block in SEND.

## Test plan
- **Basic frame:** reset; ready=1; send signalNumber=8'h02, adder=32'h0014DF75, amplitude=32'h000F4240 → accepted bytes 73 02 00 14 DF 75 00 0F 42 40 65 on 11 consecutive edges; `done` pulses once on the cycle after the last acceptance.
- **Backpressure:** same frame with ready toggling 1,0,0,1,… → identical byte sequence; data and valid stable through every ready=0 cycle; duration grows by the count of stalled cycles.
- **Snapshot and ignored send:** change adder to 32'hFFFFFFFF and pulse `send` mid-frame → the frame still carries 00 14 DF 75; no second frame follows.
- **Back-to-back:** pulse `send` on the first IDLE cycle after `done` with signalNumber=8'h05 → second frame starts the next cycle and its byte 1 = 05.
- **Reset mid-frame:** assert `reset_n`=0 after the 4th accepted byte → valid, busy and done drop to 0 immediately; after release with no `send`, no further bytes appear.
- **Loopback:** feed the byte stream into the UART receive parser → the parser outputs signalNumber=2, adder=1367925, amplitude=1000000.
